// File: rtl/issue_slot_ctrl.sv
// Issue-queue slot controller: tracks per-entry valid/ready state and payload,
// allocates the lowest free slots to enqueue ports and offers the lowest ready entries on dequeue ports.
module issue_slot_ctrl #(
  parameter int Depth     = 8,
  parameter int EnqWidth  = 2,
  parameter int SelWidth  = 2,
  parameter int DataWidth = 32,
  parameter int PtrWidth  = $clog2(Depth)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [EnqWidth-1:0]                 enq_vld_i,
  input  logic [EnqWidth-1:0][DataWidth-1:0]  enq_data_i,
  input  logic [EnqWidth-1:0]                 enq_wake_i,
  output logic [EnqWidth-1:0]                 enq_rdy_o,
  output logic [EnqWidth-1:0][PtrWidth-1:0]   enq_idx_o,
  input  logic [Depth-1:0]                    wakeup_mask_i,
  output logic [SelWidth-1:0]                 deq_vld_o,
  output logic [SelWidth-1:0][PtrWidth-1:0]   deq_idx_o,
  output logic [SelWidth-1:0][DataWidth-1:0]  deq_data_o,
  input  logic [SelWidth-1:0]                 deq_rdy_i,
  output logic [Depth-1:0]                    entry_vld_o,
  output logic [$clog2(Depth+1)-1:0]          free_cnt_o
);

  localparam int CntWidth = $clog2(Depth+1);

  logic [Depth-1:0]     vld_q, vld_d;
  logic [Depth-1:0]     rdy_q, rdy_d;
  logic [DataWidth-1:0] data_q [Depth];
  logic                 gate;

  assign gate        = rst | flush_i;
  assign entry_vld_o = vld_q;

  // Port i takes the i-th free slot; selection ignores other ports' requests.
  always_comb begin : enq_sel
    int seen;
    enq_rdy_o = '0;
    enq_idx_o = '0;
    for (int i = 0; i < EnqWidth; i++) begin
      seen = 0;
      for (int k = 0; k < Depth; k++) begin
        if (!vld_q[k]) begin
          if (seen == i && !gate) begin
            enq_rdy_o[i] = 1'b1;
            enq_idx_o[i] = PtrWidth'(k);
          end
          seen++;
        end
      end
    end
  end

  always_comb begin : deq_sel
    int seen;
    deq_vld_o  = '0;
    deq_idx_o  = '0;
    deq_data_o = '0;
    for (int j = 0; j < SelWidth; j++) begin
      seen = 0;
      for (int k = 0; k < Depth; k++) begin
        if (vld_q[k] && rdy_q[k]) begin
          if (seen == j && !gate) begin
            deq_vld_o[j]  = 1'b1;
            deq_idx_o[j]  = PtrWidth'(k);
            deq_data_o[j] = data_q[k];
          end
          seen++;
        end
      end
    end
  end

  always_comb begin : free_count
    logic [CntWidth-1:0] used;
    used = '0;
    for (int k = 0; k < Depth; k++) used = used + CntWidth'(vld_q[k]);
    free_cnt_o = CntWidth'(Depth) - used;
  end

  // Dequeue clears after wakeup so it wins; enqueue slots are free, so the wakeup mask cannot touch them.
  always_comb begin
    vld_d = vld_q;
    rdy_d = rdy_q | (wakeup_mask_i & vld_q);
    for (int j = 0; j < SelWidth; j++) begin
      if (deq_vld_o[j] && deq_rdy_i[j]) begin
        vld_d[deq_idx_o[j]] = 1'b0;
        rdy_d[deq_idx_o[j]] = 1'b0;
      end
    end
    for (int i = 0; i < EnqWidth; i++) begin
      if (enq_vld_i[i] && enq_rdy_o[i]) begin
        vld_d[enq_idx_o[i]] = 1'b1;
        rdy_d[enq_idx_o[i]] = enq_wake_i[i];
      end
    end
    if (flush_i) begin
      vld_d = '0;
      rdy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      rdy_q <= '0;
    end else begin
      vld_q <= vld_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < EnqWidth; i++) begin
      if (enq_vld_i[i] && enq_rdy_o[i]) data_q[enq_idx_o[i]] <= enq_data_i[i];
    end
  end

endmodule

// File: tb/tb_issue_slot_ctrl.sv
// Bench for issue_slot_ctrl: directed scenarios then random traffic, all checked against a queue-based model.
module tb_issue_slot_ctrl;
  localparam int D = 8, E = 2, S = 2, W = 32, P = 3, C = 4;

  logic clk = 1'b0;
  logic rst, flush_i;
  logic [E-1:0]        enq_vld_i, enq_wake_i, enq_rdy_o;
  logic [E-1:0][W-1:0] enq_data_i;
  logic [E-1:0][P-1:0] enq_idx_o;
  logic [D-1:0]        wakeup_mask_i, entry_vld_o;
  logic [S-1:0]        deq_vld_o, deq_rdy_i;
  logic [S-1:0][P-1:0] deq_idx_o;
  logic [S-1:0][W-1:0] deq_data_o;
  logic [C-1:0]        free_cnt_o;

  issue_slot_ctrl #(.Depth(D), .EnqWidth(E), .SelWidth(S), .DataWidth(W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_vld_i(enq_vld_i), .enq_data_i(enq_data_i), .enq_wake_i(enq_wake_i),
    .enq_rdy_o(enq_rdy_o), .enq_idx_o(enq_idx_o),
    .wakeup_mask_i(wakeup_mask_i),
    .deq_vld_o(deq_vld_o), .deq_idx_o(deq_idx_o), .deq_data_o(deq_data_o), .deq_rdy_i(deq_rdy_i),
    .entry_vld_o(entry_vld_o), .free_cnt_o(free_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit          mv [D];
  bit          mr [D];
  logic [W-1:0] md [D];

  logic [E-1:0]        e_enq_rdy;
  logic [E-1:0][P-1:0] e_enq_idx;
  logic [S-1:0]        e_deq_vld;
  logic [S-1:0][P-1:0] e_deq_idx;
  logic [S-1:0][W-1:0] e_deq_data;
  logic [D-1:0]        e_vld;
  logic [C-1:0]        e_free;

  function automatic void calc();
    int fq[$];
    int rq[$];
    e_enq_rdy = '0; e_enq_idx = '0; e_deq_vld = '0; e_deq_idx = '0; e_deq_data = '0;
    for (int k = 0; k < D; k++) begin
      e_vld[k] = mv[k];
      if (!mv[k]) fq.push_back(k);
      else if (mr[k]) rq.push_back(k);
    end
    e_free = C'(fq.size());
    if (!(rst || flush_i)) begin
      for (int i = 0; i < E; i++)
        if (i < fq.size()) begin e_enq_rdy[i] = 1'b1; e_enq_idx[i] = P'(fq[i]); end
      for (int j = 0; j < S; j++)
        if (j < rq.size()) begin
          e_deq_vld[j] = 1'b1; e_deq_idx[j] = P'(rq[j]); e_deq_data[j] = md[rq[j]];
        end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit nv [D];
    bit nr [D];
    @(negedge clk);
    calc();
    chk("entry_vld", 64'(entry_vld_o), 64'(e_vld));
    chk("free_cnt",  64'(free_cnt_o),  64'(e_free));
    chk("enq_rdy",   64'(enq_rdy_o),   64'(e_enq_rdy));
    chk("enq_idx",   64'(enq_idx_o),   64'(e_enq_idx));
    chk("deq_vld",   64'(deq_vld_o),   64'(e_deq_vld));
    chk("deq_idx",   64'(deq_idx_o),   64'(e_deq_idx));
    chk("deq_data",  64'(deq_data_o),  64'(e_deq_data));
    nv = mv; nr = mr;
    if (rst || flush_i) begin
      for (int k = 0; k < D; k++) begin nv[k] = 1'b0; nr[k] = 1'b0; end
    end else begin
      for (int k = 0; k < D; k++) if (wakeup_mask_i[k] && mv[k]) nr[k] = 1'b1;
      for (int j = 0; j < S; j++)
        if (e_deq_vld[j] && deq_rdy_i[j]) begin nv[e_deq_idx[j]] = 1'b0; nr[e_deq_idx[j]] = 1'b0; end
      for (int i = 0; i < E; i++)
        if (e_enq_rdy[i] && enq_vld_i[i]) begin
          nv[e_enq_idx[i]] = 1'b1; nr[e_enq_idx[i]] = enq_wake_i[i]; md[e_enq_idx[i]] = enq_data_i[i];
        end
    end
    @(posedge clk);
    mv = nv; mr = nr;
    #1;
  endtask

  task automatic idle();
    flush_i = 0; enq_vld_i = '0; enq_wake_i = '0; wakeup_mask_i = '0; deq_rdy_i = '0;
    enq_data_i = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int k = 0; k < D; k++) begin mv[k] = 0; mr[k] = 0; md[k] = '0; end
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idx", 64'(enq_idx_o), 64'(6'b001_000));

    // enqueue after reset
    enq_vld_i = 2'b11; enq_data_i = {32'hB, 32'hA}; enq_wake_i = 2'b01;
    step();
    idle(); step();
    chk("enq1_vld", 64'(entry_vld_o), 64'h03);
    chk("enq1_data", 64'(deq_data_o[0]), 64'hA);

    // fill to full
    repeat (3) begin
      enq_vld_i = 2'b11; enq_data_i = {$urandom, $urandom};
      step();
    end
    idle(); step();
    chk("full_vld", 64'(entry_vld_o), 64'hFF);
    chk("full_rdy", 64'(enq_rdy_o), 64'h0);
    deq_rdy_i = 2'b01; step();
    idle(); step();
    chk("freed_rdy", 64'(enq_rdy_o), 64'h1);
    chk("freed_idx", 64'(enq_idx_o[0]), 64'h0);
    enq_vld_i = 2'b01; enq_wake_i = 2'b00; step();

    // wakeup and refill
    idle(); wakeup_mask_i = 8'hA4; step();
    idle(); step();
    chk("wk_deq_vld", 64'(deq_vld_o), 64'h3);
    chk("wk_deq_idx", 64'(deq_idx_o), 64'h2A);
    deq_rdy_i = 2'b11; step();
    idle(); step();
    chk("wk_after", 64'(entry_vld_o), 64'hDB);
    chk("refill_idx", 64'(enq_idx_o), 64'h2A);
    enq_vld_i = 2'b11; step();
    idle(); deq_rdy_i = 2'b01; step();
    idle(); step();
    chk("drop7", 64'(entry_vld_o), 64'h7F);

    // independent dequeue ports
    wakeup_mask_i = 8'h12; step();
    idle(); deq_rdy_i = 2'b10; step();
    idle(); step();
    chk("ind_vld", 64'(entry_vld_o), 64'h6F);
    chk("ind_deq", 64'(deq_vld_o), 64'h1);
    chk("ind_idx", 64'(deq_idx_o[0]), 64'h1);

    // wakeup racing a dequeue of the same entry
    wakeup_mask_i = 8'h08; step();
    idle(); deq_rdy_i = 2'b11; wakeup_mask_i = 8'h08; step();
    idle(); step();
    chk("race_vld", 64'(entry_vld_o), 64'h65);
    chk("race_deq", 64'(deq_vld_o), 64'h0);

    // flush then reset mid-traffic
    enq_vld_i = 2'b11; deq_rdy_i = 2'b11; enq_wake_i = 2'b11; flush_i = 1'b1; step();
    idle(); step();
    chk("flush_vld", 64'(entry_vld_o), 64'h0);
    chk("flush_cnt", 64'(free_cnt_o), 64'd8);
    enq_vld_i = 2'b11; enq_wake_i = 2'b11; step();
    step();
    rst = 1'b1; deq_rdy_i = 2'b11; step();
    rst = 1'b0; idle(); step();
    chk("rst_vld", 64'(entry_vld_o), 64'h0);
    chk("rst_cnt", 64'(free_cnt_o), 64'd8);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      enq_vld_i     = E'($urandom);
      enq_wake_i    = E'($urandom);
      enq_data_i    = {$urandom, $urandom};
      wakeup_mask_i = D'($urandom & $urandom);
      deq_rdy_i     = S'($urandom);
      flush_i       = ($urandom_range(0, 39) == 0);
      rst           = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0; idle(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/issue_slot_ctrl.md
# issue_slot_ctrl

Multi-port issue-queue slot controller wrapped around the static lowest-index priority selection scheme. It owns the per-entry valid/ready state and payload storage for a Depth-entry unordered queue. Each cycle it grants up to EnqWidth enqueues into the lowest-index free slots and offers up to SelWidth ready entries, lowest index first, on dequeue ports with valid/ready handshakes. It sits between a dispatch stage (enqueue side) and an issue/consumer stage (dequeue side), with wakeup driven externally.

## Interface
- Depth, 8, number of entries (>=2)
- EnqWidth, 2, enqueue ports (<=Depth)
- SelWidth, 2, dequeue ports (<=Depth)
- DataWidth, 32, payload bits per entry
- PtrWidth, $clog2(Depth), derived index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all entries
- enq_vld_i  in  [EnqWidth]  enqueue request per port
- enq_data_i  in  [EnqWidth][DataWidth]  enqueue payload
- enq_wake_i  in  [EnqWidth]  entry enters already ready
- enq_rdy_o  out  [EnqWidth]  port has a slot this cycle
- enq_idx_o  out  [EnqWidth][PtrWidth]  slot assigned to port
- wakeup_mask_i  in  [Depth]  set ready bit of listed valid entries
- deq_vld_o  out  [SelWidth]  ready entry offered on port
- deq_idx_o  out  [SelWidth][PtrWidth]  offered entry index
- deq_data_o  out  [SelWidth][DataWidth]  offered entry payload
- deq_rdy_i  in  [SelWidth]  consumer accepts
- entry_vld_o  out  [Depth]  registered valid vector
- free_cnt_o  out  [$clog2(Depth+1)]  number of free entries

## Operation
- State: vld[Depth], rdy[Depth] (both reset to 0), data[Depth][DataWidth] (not reset).
- Enqueue select: port i maps to the i-th lowest-index slot with vld=0, computed from registered vld only. enq_rdy_o[i]=1 iff that slot exists. enq_idx_o[i] is its index (0 when enq_rdy_o[i]=0). A port's mapping does not depend on enq_vld_i of other ports.
- Enqueue fire (enq_vld_i[i] & enq_rdy_o[i]): the slot gets vld=1, rdy=enq_wake_i[i], data=enq_data_i[i].
- Dequeue select: port j offers the j-th lowest-index entry with vld&rdy. deq_vld_o[j]=1 iff it exists. deq_idx_o/deq_data_o hold that entry's index and data (idx and data 0 when not valid).
- Dequeue fire (deq_vld_o[j] & deq_rdy_i[j]): the entry's vld and rdy are cleared. Ports are independent; a stalled port does not block other ports.
- Wakeup: for each k with wakeup_mask_i[k] & vld[k], set rdy[k]. Bits for invalid entries are ignored.
- Wakeup on an entry dequeued the same cycle: dequeue wins and the entry is cleared.
- Wakeup bit on a slot being enqueued the same cycle: ignored; only enq_wake_i applies.
- A slot freed by dequeue cannot be enqueued until the next cycle.
- free_cnt_o = Depth - popcount(vld), registered-state based.
- Flush: when flush_i=1, enq_rdy_o and deq_vld_o are forced 0 and no handshake fires. Next cycle all vld=0 and rdy=0.
- rst behaves like flush. rst mid-operation drops all entries with no partial effects.

## Timing
- All outputs are combinational from registered state, plus flush_i/rst gating. There is no input-to-output combinational path other than flush_i/rst.
- In the cycle after rst is released: entry_vld_o=0, free_cnt_o=Depth, enq_rdy_o=all 1, enq_idx_o[i]=i, deq_vld_o=0.
- While rst=1: enq_rdy_o=0, deq_vld_o=0.
- An enqueue at cycle t with enq_wake_i=1 is offered on dequeue at t+1 at the earliest.
- A wakeup at cycle t is visible on dequeue at t+1.
- A dequeue fire at t frees the slot at t+1; enq_rdy_o reflects this at t+1.
- Full (free_cnt_o=0): all enq_rdy_o=0. With free_cnt_o=f<EnqWidth, only ports 0..f-1 are ready.
- Empty or no ready entries: all deq_vld_o=0.

## Test plan
- Enqueue after reset:
  - Stimulus: enq_vld_i=11, data 0xA/0xB, enq_wake_i=01.
  - Next cycle: entry_vld_o=0x03, free_cnt_o=6, deq_vld_o=01, deq_idx_o[0]=0, deq_data_o[0]=0xA, enq_idx_o={3,2}.
- Fill to full:
  - Stimulus: four dual enqueues.
  - Response: entry_vld_o=0xFF, enq_rdy_o=00, free_cnt_o=0.
  - Then dequeue one entry: enq_rdy_o=01 with enq_idx_o[0] equal to the freed index.
- Wakeup and refill:
  - Stimulus: full queue, all rdy=0; wakeup_mask_i=0xA4.
  - Next cycle: deq_vld_o=11, deq_idx_o={5,2}.
  - With deq_rdy_i=11: following cycle entry_vld_o=0xDB, a subsequent dual enqueue lands in slots 2 and 5.
- Independent ports:
  - Stimulus: ready entries 1,4; deq_rdy_i=10.
  - Response: only entry 4 is cleared; next cycle port 0 still offers entry 1 and port 1 is idle.
- Same-cycle conflict:
  - Stimulus: wakeup_mask_i bit 3 while entry 3 dequeues.
  - Response: entry 3 is cleared, vld[3]=0 and rdy[3]=0 next cycle. Slot 3 is not offered to enqueue in the same cycle.
- Flush/reset mid-traffic:
  - Stimulus: flush_i=1 with enq_vld_i=11 and deq_rdy_i=11.
  - Response: enq_rdy_o=00 and deq_vld_o=00 that cycle; next cycle entry_vld_o=0, free_cnt_o=8.
  - Repeat with rst: same result.
